// File: rtl/vector_expand_unit.sv
// Scalar-to-vector expansion: turns a stream of scalars into LANES-wide vectors
// by broadcast, pack (gather) or scatter, each tagged with a lane-valid mask.
module vector_expand_unit #(
   parameter  int DATA_WIDTH = 16,
   parameter  int LANES      = 16,
   localparam int LW         = $clog2(LANES)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        valid_in,
   output logic                        ready_in,
   input  logic                        flush_in,
   input  logic [2:0]                  expand_type,
   input  logic [LW-1:0]               lane_sel,
   output logic [DATA_WIDTH*LANES-1:0] data_out,
   output logic [LANES-1:0]            lane_mask,
   output logic                        valid_out,
   input  logic                        ready_out,
   output logic [1:0]                  state_dbg,
   output logic [1:0]                  mode_dbg
);

   // Handshake: a beat moves on valid_in && ready_in at a rising edge, a vector
   // on valid_out && ready_out; valid_out never drops before its transfer.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_OUTPUT = 2'd2} state_t;
   typedef enum logic [1:0] {M_BCAST = 2'd0, M_PACK = 2'd1, M_SCATTER = 2'd2} mode_t;

   localparam int VW = DATA_WIDTH * LANES;

   state_t          state_q;
   mode_t           mode_q;
   logic [LW-1:0]   count_q;
   logic [VW-1:0]   data_q;
   logic [LANES-1:0] mask_q;

   logic [VW-1:0]    scat_vec;
   logic [LANES-1:0] scat_mask;
   logic [VW-1:0]    pack_first;
   logic             last_lane;

   always_comb begin
      scat_vec = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_sel == LW'(k)) scat_vec[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
   end

   assign scat_mask  = LANES'(1) << lane_sel;
   assign pack_first = {{(VW-DATA_WIDTH){1'b0}}, data_in};
   assign last_lane  = (count_q == LW'(LANES-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= M_BCAST;
         count_q <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_in) begin
                  case (expand_type)
                     3'd1: begin
                        mode_q <= M_PACK;
                        data_q <= pack_first;
                        mask_q <= LANES'(1);
                        if (flush_in) begin
                           state_q <= S_OUTPUT;
                           count_q <= '0;
                        end else begin
                           state_q <= S_FILL;
                           count_q <= LW'(1);
                        end
                     end
                     3'd2: begin
                        mode_q  <= M_SCATTER;
                        data_q  <= scat_vec;
                        mask_q  <= scat_mask;
                        state_q <= S_OUTPUT;
                     end
                     default: begin
                        mode_q  <= M_BCAST;
                        data_q  <= {LANES{data_in}};
                        mask_q  <= '1;
                        state_q <= S_OUTPUT;
                     end
                  endcase
               end
            end
            S_FILL: begin
               // Only pack reaches here, so mode/lane_sel/expand_type are irrelevant.
               if (valid_in) begin
                  data_q[count_q*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                  mask_q[count_q] <= 1'b1;
                  if (last_lane || flush_in) begin
                     state_q <= S_OUTPUT;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + LW'(1);
                  end
               end
            end
            S_OUTPUT: begin
               if (ready_out) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_in  = (state_q != S_OUTPUT);
   assign valid_out = (state_q == S_OUTPUT);
   assign data_out  = data_q;
   assign lane_mask = mask_q;
   assign state_dbg = state_q;
   assign mode_dbg  = mode_q;

endmodule

// File: tb/tb_vector_expand_unit.sv
// Directed bench for vector_expand_unit: hand-computed vectors checked through
// an expected queue, with latency, backpressure and reset-abort cases.
module tb_vector_expand_unit;

   localparam int DW = 16;
   localparam int LN = 16;
   localparam int VW = DW * LN;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] data_in;
   logic          valid_in;
   logic          ready_in;
   logic          flush_in;
   logic [2:0]    expand_type;
   logic [3:0]    lane_sel;
   logic [VW-1:0] data_out;
   logic [LN-1:0] lane_mask;
   logic          valid_out;
   logic          ready_out;
   logic [1:0]    state_dbg;
   logic [1:0]    mode_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   logic [VW+LN-1:0] exp_q[$];

   vector_expand_unit #(.DATA_WIDTH(DW), .LANES(LN)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_in), .flush_in(flush_in), .expand_type(expand_type),
      .lane_sel(lane_sel), .data_out(data_out), .lane_mask(lane_mask),
      .valid_out(valid_out), .ready_out(ready_out), .state_dbg(state_dbg),
      .mode_dbg(mode_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [VW+LN-1:0] act, input logic [VW+LN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Called at a falling edge; returns 1 time unit after the accepting edge.
   task automatic drive_beat(input logic [DW-1:0] d, input logic [2:0] t, input logic [3:0] s, input logic f);
      check_eq("beat_ready", ready_in, 1);
      valid_in = 1'b1; data_in = d; expand_type = t; lane_sel = s; flush_in = f;
      @(posedge clk); #1;
      valid_in = 1'b0; flush_in = 1'b0;
   endtask

   task automatic expect_vec(input logic [VW-1:0] d, input logic [LN-1:0] m);
      exp_q.push_back({m, d});
   endtask

   // Vector must be valid in the cycle after the final accept; with ready_out
   // high it must be gone (and ready_in back) one cycle later.
   task automatic collect(input string tag);
      logic [VW+LN-1:0] e;
      @(negedge clk);
      check_eq({tag, "_valid"}, valid_out, 1);
      check_eq({tag, "_rdy_low"}, ready_in, 0);
      if (exp_q.size() == 0) begin
         check_eq({tag, "_queue_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, "_data"}, data_out, e[VW-1:0]);
         check_eq({tag, "_mask"}, lane_mask, e[VW+LN-1:VW]);
      end
      @(negedge clk);
      check_eq({tag, "_done_valid"}, valid_out, 0);
      check_eq({tag, "_done_rdy"}, ready_in, 1);
   endtask

   initial begin
      logic [VW-1:0] v;
      rst_n = 1'b0; data_in = '0; valid_in = 1'b0; flush_in = 1'b0;
      expand_type = '0; lane_sel = '0; ready_out = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_data", data_out, 0);
      check_eq("rst_mask", lane_mask, 0);
      check_eq("rst_valid", valid_out, 0);
      check_eq("rst_ready", ready_in, 1);
      check_eq("rst_state", state_dbg, 0);
      check_eq("rst_mode", mode_dbg, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // broadcast
      expect_vec({16{16'h1234}}, 16'hFFFF);
      drive_beat(16'h1234, 3'd0, 4'd0, 1'b0);
      collect("bcast");

      // scatter to lanes 5 and 15, and an out-of-range type acting as broadcast
      expect_vec(256'hBEEF << 80, 16'h0020);
      drive_beat(16'hBEEF, 3'd2, 4'd5, 1'b0);
      collect("scat5");
      expect_vec(256'hBEEF << 240, 16'h8000);
      drive_beat(16'hBEEF, 3'd2, 4'd15, 1'b0);
      collect("scat15");
      expect_vec({16{16'h0A0A}}, 16'hFFFF);
      drive_beat(16'h0A0A, 3'd6, 4'd3, 1'b1);
      collect("type6_bcast");

      // full pack with idle gaps and expand_type wandering after the first beat
      v = {16'h0010, 16'h000F, 16'h000E, 16'h000D, 16'h000C, 16'h000B, 16'h000A, 16'h0009,
           16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
      expect_vec(v, 16'hFFFF);
      for (int i = 0; i < 16; i++) begin
         drive_beat(DW'(i + 1), (i == 0) ? 3'd1 : 3'(i % 3), 4'(i), 1'b0);
         if (i < 15) begin
            @(negedge clk);
            check_eq("pack16_busy", valid_out, 0);
            if (i % 4 == 1) begin
               repeat (2) @(negedge clk);
               check_eq("pack16_stall", state_dbg, 1);
            end
         end
      end
      collect("pack16");

      // short pack with flush on the third beat; idle flush in between is ignored
      expect_vec(256'h000C_000B_000A, 16'h0007);
      drive_beat(16'h000A, 3'd1, 4'd0, 1'b0);
      @(negedge clk);
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      check_eq("idle_flush", valid_out, 0);
      drive_beat(16'h000B, 3'd0, 4'd0, 1'b0);
      @(negedge clk);
      drive_beat(16'h000C, 3'd2, 4'd9, 1'b1);
      collect("pack3");
      expect_vec(256'h0077, 16'h0001);
      drive_beat(16'h0077, 3'd1, 4'd0, 1'b1);
      collect("pack1");

      // backpressure: vector held while a new beat waits
      ready_out = 1'b0;
      drive_beat(16'h0303, 3'd2, 4'd3, 1'b0);
      valid_in = 1'b1; data_in = 16'hFFFF; expand_type = 3'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("bp_valid", valid_out, 1);
         check_eq("bp_ready", ready_in, 0);
         check_eq("bp_data", data_out, 256'h0303 << 48);
         check_eq("bp_mask", lane_mask, 16'h0008);
      end
      ready_out = 1'b1;
      @(negedge clk);
      check_eq("bp_rel_valid", valid_out, 0);
      check_eq("bp_rel_ready", ready_in, 1);
      @(negedge clk);
      valid_in = 1'b0;
      check_eq("bp_next_valid", valid_out, 1);
      check_eq("bp_next_data", data_out, {16{16'hFFFF}});
      check_eq("bp_next_mask", lane_mask, 16'hFFFF);
      @(negedge clk);
      check_eq("bp_next_done", valid_out, 0);

      // reset in the middle of a pack
      for (int i = 0; i < 7; i++) begin
         drive_beat(16'h0100 + DW'(i), 3'd1, 4'd0, 1'b0);
         @(negedge clk);
      end
      check_eq("mid_fill_state", state_dbg, 1);
      rst_n = 1'b0;
      #2;
      check_eq("abort_data", data_out, 0);
      check_eq("abort_mask", lane_mask, 0);
      check_eq("abort_valid", valid_out, 0);
      check_eq("abort_ready", ready_in, 1);
      check_eq("abort_state", state_dbg, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("abort_no_out", valid_out, 0);
      expect_vec({16{16'h0055}}, 16'hFFFF);
      drive_beat(16'h0055, 3'd0, 4'd0, 1'b0);
      collect("post_abort");

      check_eq("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
